// File: rtl/ibex_lsu_split_unit_if.sv
// Bundle of the execute-stage request, data-bus and writeback-response signals of the LSU.
// The master modport is the LSU itself; the slave modport is the surrounding pipeline/bus.
interface ibex_lsu_split_unit_if;
    logic        lsu_req_i;
    logic        lsu_ready_o;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;
    logic        busy_o;

    modport master (
        input  lsu_req_i, lsu_we_i, lsu_type_i, lsu_sign_ext_i, lsu_addr_i, lsu_wdata_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        output lsu_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output rf_wdata_lsu_o, rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, busy_o
    );

    modport slave (
        output lsu_req_i, lsu_we_i, lsu_type_i, lsu_sign_ext_i, lsu_addr_i, lsu_wdata_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        input  lsu_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  rf_wdata_lsu_o, rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, busy_o
    );
endinterface

// File: rtl/ibex_lsu_split_unit.sv
// Load/store engine: one access at a time, misaligned accesses split into two aligned beats,
// load data aligned and extended with zero added latency on the final response.
module ibex_lsu_split_unit (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    ibex_lsu_split_unit_if.master        lsu
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_GNT  = 3'd1,
        S_WAIT_RV   = 3'd2,
        S_WAIT_GNT2 = 3'd3,
        S_WAIT_RV2  = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_type;
    logic        r_sign_ext;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_idle;
    logic        w_beat2;
    logic        w_final;
    logic        w_bus_act;
    logic        w_split;
    logic        w_we;
    logic [1:0]  w_type;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_off;
    logic [7:0]  w_mask8;
    logic [63:0] w_wdata64;
    logic [31:0] w_rdata_lo;
    logic [63:0] w_raw;
    logic [31:0] w_result;
    logic        w_resp_valid;
    logic        w_resp_err;
    logic        w_rf_we;

    function automatic logic [3:0] base_mask(input logic [1:0] typ);
        logic [3:0] m;
        case (typ)
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b0001;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extend(input logic [1:0] typ, input logic sx, input logic [31:0] raw);
        logic [31:0] v;
        case (typ)
            2'd1:    v = {{16{sx & raw[15]}}, raw[15:0]};
            2'd2:    v = {{24{sx & raw[7]}}, raw[7:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    // Bus request, beat geometry and response datapath.
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_beat2   = (r_state == S_WAIT_GNT2) || (r_state == S_WAIT_RV2);
        w_final   = ((r_state == S_WAIT_RV) && !w_split) || (r_state == S_WAIT_RV2);
        w_bus_act = !w_idle || lsu.lsu_req_i;

        // In IDLE the request is presented straight from the execute stage.
        if (w_idle) begin
            w_we    = lsu.lsu_we_i;
            w_type  = lsu.lsu_type_i;
            w_addr  = lsu.lsu_addr_i;
            w_wdata = lsu.lsu_wdata_i;
        end else begin
            w_we    = r_we;
            w_type  = r_type;
            w_addr  = r_addr;
            w_wdata = r_wdata;
        end

        w_off     = w_addr[1:0];
        w_mask8   = {4'b0000, base_mask(w_type)} << w_off;
        w_split   = (w_mask8[7:4] != 4'b0000);
        w_wdata64 = {w_wdata, w_wdata} << {w_off, 3'b000};

        // Unsplit accesses see the same word in both halves of the shifter.
        w_rdata_lo   = (r_state == S_WAIT_RV2) ? r_rdata : lsu.data_rdata_i;
        w_raw        = {lsu.data_rdata_i, w_rdata_lo} >> {w_off, 3'b000};
        w_result     = extend(r_type, r_sign_ext, w_raw[31:0]);

        w_resp_valid = w_final && lsu.data_rvalid_i;
        w_resp_err   = w_resp_valid && (lsu.data_err_i || ((r_state == S_WAIT_RV2) && r_err));
        w_rf_we      = w_resp_valid && !r_we && !w_resp_err;

        case (r_state)
            S_IDLE:      lsu.data_req_o = lsu.lsu_req_i;
            S_WAIT_GNT:  lsu.data_req_o = 1'b1;
            S_WAIT_GNT2: lsu.data_req_o = 1'b1;
            default:     lsu.data_req_o = 1'b0;
        endcase

        if (w_bus_act) begin
            lsu.data_addr_o  = {w_addr[31:2], 2'b00} + (w_beat2 ? 32'd4 : 32'd0);
            lsu.data_we_o    = w_we;
            lsu.data_be_o    = w_beat2 ? w_mask8[7:4] : w_mask8[3:0];
            lsu.data_wdata_o = w_beat2 ? w_wdata64[63:32] : w_wdata64[31:0];
        end else begin
            lsu.data_addr_o  = 32'd0;
            lsu.data_we_o    = 1'b0;
            lsu.data_be_o    = 4'b0000;
            lsu.data_wdata_o = 32'd0;
        end

        lsu.lsu_resp_valid_o = w_resp_valid;
        lsu.lsu_resp_err_o   = w_resp_err;
        lsu.rf_we_lsu_o      = w_rf_we;
        lsu.rf_wdata_lsu_o   = w_rf_we ? w_result : 32'd0;
        lsu.busy_o           = !w_idle;
        lsu.lsu_ready_o      = w_idle;
    end

    // Access FSM and request/beat-1 capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_type     <= 2'd0;
            r_sign_ext <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lsu.lsu_req_i) begin
                        r_we       <= lsu.lsu_we_i;
                        r_type     <= lsu.lsu_type_i;
                        r_sign_ext <= lsu.lsu_sign_ext_i;
                        r_addr     <= lsu.lsu_addr_i;
                        r_wdata    <= lsu.lsu_wdata_i;
                        r_err      <= 1'b0;
                        r_state    <= lsu.data_gnt_i ? S_WAIT_RV : S_WAIT_GNT;
                    end
                end
                S_WAIT_GNT: begin
                    if (lsu.data_gnt_i) r_state <= S_WAIT_RV;
                end
                S_WAIT_RV: begin
                    if (lsu.data_rvalid_i) begin
                        if (w_split) begin
                            r_rdata <= lsu.data_rdata_i;
                            r_err   <= lsu.data_err_i;
                            r_state <= S_WAIT_GNT2;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WAIT_GNT2: begin
                    if (lsu.data_gnt_i) r_state <= S_WAIT_RV2;
                end
                S_WAIT_RV2: begin
                    if (lsu.data_rvalid_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_lsu_split_unit.sv
// Bench for ibex_lsu_split_unit: byte-addressed memory model acting as the data bus,
// directed test-plan accesses followed by randomized loads/stores.
module tb_ibex_lsu_split_unit;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    ibex_lsu_split_unit_if bus();

    ibex_lsu_split_unit dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lsu    (bus.master)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] typ);
        return (typ == 2'd1) ? 2 : (typ == 2'd2) ? 1 : 4;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = a + 32'(i);
            v[8*i +: 8] = mem[t[9:0]];
        end
        return v;
    endfunction

    task automatic wr_word(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = a + 32'(i);
            mem[t[9:0]] = v[8*i +: 8];
        end
    endtask

    // Expected load: bytes addr..addr+size-1 little-endian, then extended.
    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] typ, input logic sx);
        logic [31:0] v;
        int sz;
        sz = size_of(typ);
        v  = 32'd0;
        for (int i = 0; i < sz; i++) begin
            logic [31:0] t;
            t = addr + 32'(i);
            v[8*i +: 8] = mem[t[9:0]];
        end
        if (sx && sz == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (sx && sz == 2 && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    // A lane is enabled when its byte address lies within [addr, addr+size).
    function automatic logic [3:0] exp_be(input logic [31:0] ba, input logic [31:0] addr, input int sz);
        logic [3:0] be;
        for (int j = 0; j < 4; j++) begin
            logic [31:0] k;
            k = ba + 32'(j) - addr;
            be[j] = (k < 32'(sz));
        end
        return be;
    endfunction

    task automatic idle_inputs();
        bus.lsu_req_i      = 1'b0;
        bus.lsu_we_i       = 1'b0;
        bus.lsu_type_i     = 2'd0;
        bus.lsu_sign_ext_i = 1'b0;
        bus.lsu_addr_i     = 32'd0;
        bus.lsu_wdata_i    = 32'd0;
        bus.data_gnt_i     = 1'b0;
        bus.data_rvalid_i  = 1'b0;
        bus.data_rdata_i   = 32'd0;
        bus.data_err_i     = 1'b0;
    endtask

    task automatic access(input logic we, input logic [1:0] typ, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gd1, input int gd2, input int rvd, input logic e1, input logic e2,
                          output logic [3:0] o_be1, output logic [3:0] o_be2,
                          output logic [31:0] o_wd1, output logic [31:0] o_wd2,
                          output logic [31:0] o_res, output logic o_err);
        int sz, nb, gd, pulses;
        logic [31:0] base, ba, expv;
        logic [3:0] be;
        logic experr, exprfwe;
        sz      = size_of(typ);
        nb      = (int'(addr[1:0]) + sz > 4) ? 2 : 1;
        base    = {addr[31:2], 2'b00};
        expv    = exp_load(addr, typ, sx);
        experr  = e1 | ((nb == 2) && e2);
        exprfwe = !we && !experr;
        pulses  = 0;
        o_be1 = 4'd0; o_be2 = 4'd0; o_wd1 = 32'd0; o_wd2 = 32'd0; o_res = 32'd0; o_err = 1'b0;
        for (int b = 0; b < nb; b++) begin
            ba = base + 32'(4 * b);
            be = exp_be(ba, addr, sz);
            gd = (b == 0) ? gd1 : gd2;
            for (int c = 0; c <= gd; c++) begin
                @(negedge clk_i);
                bus.lsu_req_i = (b == 0 && c == 0);
                if (b == 0 && c == 0) begin
                    bus.lsu_we_i       = we;
                    bus.lsu_type_i     = typ;
                    bus.lsu_sign_ext_i = sx;
                    bus.lsu_addr_i     = addr;
                    bus.lsu_wdata_i    = wd;
                end else begin
                    bus.lsu_addr_i  = $urandom;
                    bus.lsu_wdata_i = $urandom;
                end
                bus.data_gnt_i    = (c == gd);
                bus.data_rvalid_i = (c != gd) && ($urandom_range(0, 2) == 0);
                bus.data_rdata_i  = $urandom;
                bus.data_err_i    = 1'($urandom_range(0, 1));
                #1;
                chk("req", 32'(bus.data_req_o), 32'd1);
                chk("ready", 32'(bus.lsu_ready_o), (b == 0 && c == 0) ? 32'd1 : 32'd0);
                chk("addr", bus.data_addr_o, ba);
                chk("be", 32'(bus.data_be_o), 32'(be));
                chk("we", 32'(bus.data_we_o), 32'(we));
                chk("no_resp_req", 32'(bus.lsu_resp_valid_o), 32'd0);
                if (we) begin
                    for (int j = 0; j < 4; j++) begin
                        if (be[j]) begin
                            logic [31:0] k, t;
                            k = ba + 32'(j) - addr;
                            t = ba + 32'(j);
                            chk("st_lane", 32'(bus.data_wdata_o[8*j +: 8]), 32'(wd[8*int'(k) +: 8]));
                            if (c == gd) mem[t[9:0]] = bus.data_wdata_o[8*j +: 8];
                        end
                    end
                end
                if (c == gd) begin
                    if (b == 0) begin o_be1 = bus.data_be_o; o_wd1 = bus.data_wdata_o; end
                    else        begin o_be2 = bus.data_be_o; o_wd2 = bus.data_wdata_o; end
                end
            end
            for (int c = 0; c <= rvd; c++) begin
                @(negedge clk_i);
                bus.lsu_req_i     = 1'b0;
                bus.data_gnt_i    = 1'b0;
                bus.data_rvalid_i = (c == rvd);
                bus.data_rdata_i  = (c == rvd) ? rd_word(ba) : $urandom;
                bus.data_err_i    = (c == rvd) ? ((b == 0) ? e1 : e2) : 1'($urandom_range(0, 1));
                #1;
                chk("req_low_rv", 32'(bus.data_req_o), 32'd0);
                chk("busy", 32'(bus.busy_o), 32'd1);
                if (c == rvd && b == nb - 1) begin
                    pulses += int'(bus.lsu_resp_valid_o);
                    chk("resp_valid", 32'(bus.lsu_resp_valid_o), 32'd1);
                    chk("resp_err", 32'(bus.lsu_resp_err_o), 32'(experr));
                    chk("rf_we", 32'(bus.rf_we_lsu_o), 32'(exprfwe));
                    chk("rf_wdata", bus.rf_wdata_lsu_o, exprfwe ? expv : 32'd0);
                    o_res = bus.rf_wdata_lsu_o;
                    o_err = bus.lsu_resp_err_o;
                end else begin
                    pulses += int'(bus.lsu_resp_valid_o);
                    chk("no_resp_wait", 32'(bus.lsu_resp_valid_o), 32'd0);
                    chk("rf_wdata_zero", bus.rf_wdata_lsu_o, 32'd0);
                end
            end
        end
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("one_pulse", 32'(pulses), 32'd1);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        chk("idle_ready", 32'(bus.lsu_ready_o), 32'd1);
    endtask

    logic [3:0]  be1, be2;
    logic [31:0] wd1, wd2, res;
    logic        rerr;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        idle_inputs();
        #1;
        chk("rst_req", 32'(bus.data_req_o), 32'd0);
        chk("rst_addr", bus.data_addr_o, 32'd0);
        chk("rst_be", 32'(bus.data_be_o), 32'd0);
        chk("rst_we", 32'(bus.data_we_o), 32'd0);
        chk("rst_resp", {28'd0, bus.lsu_resp_valid_o, bus.lsu_resp_err_o, bus.rf_we_lsu_o, bus.busy_o}, 32'd0);
        chk("rst_rfdata", bus.rf_wdata_lsu_o, 32'd0);
        chk("rst_ready", 32'(bus.lsu_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        wr_word(32'h100, 32'hDEADBEEF);
        access(1'b0, 2'd0, 1'b0, 32'h100, 32'd0, 0, 0, 0, 1'b0, 1'b0, be1, be2, wd1, wd2, res, rerr);
        chk("tp_word_be", 32'(be1), 32'hF);
        chk("tp_word_res", res, 32'hDEADBEEF);

        wr_word(32'h100, 32'h80112233);
        access(1'b0, 2'd2, 1'b1, 32'h103, 32'd0, 0, 0, 0, 1'b0, 1'b0, be1, be2, wd1, wd2, res, rerr);
        chk("tp_sbyte_be", 32'(be1), 32'h8);
        chk("tp_sbyte_res", res, 32'hFFFFFF80);
        access(1'b0, 2'd2, 1'b0, 32'h103, 32'd0, 1, 0, 1, 1'b0, 1'b0, be1, be2, wd1, wd2, res, rerr);
        chk("tp_ubyte_res", res, 32'h00000080);

        wr_word(32'h0FC, 32'hAABB0000);
        wr_word(32'h100, 32'h0000CCDD);
        access(1'b0, 2'd0, 1'b0, 32'h0FE, 32'd0, 2, 0, 0, 1'b0, 1'b0, be1, be2, wd1, wd2, res, rerr);
        chk("tp_mis_be1", 32'(be1), 32'hC);
        chk("tp_mis_be2", 32'(be2), 32'h3);
        chk("tp_mis_res", res, 32'hCCDDAABB);

        access(1'b1, 2'd1, 1'b0, 32'h0FF, 32'h00001234, 0, 1, 0, 1'b0, 1'b0, be1, be2, wd1, wd2, res, rerr);
        chk("tp_st_be1", 32'(be1), 32'h8);
        chk("tp_st_b1", 32'(wd1[31:24]), 32'h34);
        chk("tp_st_be2", 32'(be2), 32'h1);
        chk("tp_st_b2", 32'(wd2[7:0]), 32'h12);

        access(1'b0, 2'd0, 1'b0, 32'h201, 32'd0, 0, 0, 1, 1'b1, 1'b0, be1, be2, wd1, wd2, res, rerr);
        chk("tp_err_flag", 32'(rerr), 32'd1);
        chk("tp_err_data", res, 32'd0);

        access(1'b0, 2'd0, 1'b1, 32'hFFFFFFFE, 32'd0, 0, 0, 0, 1'b0, 1'b0, be1, be2, wd1, wd2, res, rerr);

        // Reset while waiting for the beat-2 grant.
        @(negedge clk_i);
        bus.lsu_req_i = 1'b1; bus.lsu_type_i = 2'd0; bus.lsu_addr_i = 32'h202; bus.data_gnt_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h11223344;
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("g2_req", 32'(bus.data_req_o), 32'd1);
        chk("g2_addr", bus.data_addr_o, 32'h204);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.data_req_o), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h55667788;
        #1;
        chk("stale_rv", 32'(bus.lsu_resp_valid_o), 32'd0);
        chk("stale_we", 32'(bus.rf_we_lsu_o), 32'd0);
        @(negedge clk_i);
        idle_inputs();

        for (int n = 0; n < 60; n++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                   be1, be2, wd1, wd2, res, rerr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
